vending_machine: RTL and testbench
==================================

// Module: vending_machine
// PURPOSE
//  Single-item vending controller. Accepts an 8-bit item code and one-hot coins while a purchase
//  session (disp) is active, accumulates credit, vends when credit >= price, and returns change.
//  Flags unknown item codes (no_item) and sessions abandoned underfunded (no_fund, full refund).
//  Leaf block between the keypad/coin-acceptor front end and the dispense/change actuators.
// PARAMETERS
//  none (price table is fixed constants, see STRUCTURE)
// PORTS
//  clk       in   1  system clock, all state updates on rising edge
//  rst       in   1  synchronous, active-high reset
//  item      in   8  selected item code, sampled at session start
//  coin_val  in   5  one-hot coin this cycle: 00001=1, 00010=2, 00100=5, 01000=10, 10000=20; 0=no coin
//  disp      in   1  session active (customer selecting/paying); falling level ends session
//  chng      out  5  change/refund amount, registered, held until next session start
//  no_fund   out  1  session ended with credit < price; held until next session start
//  no_item   out  1  item code not in price table; held while disp=1 in IDLE
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: state=IDLE, amt_ip=0, price=0, chng=0,
//    no_fund=0, no_item=0.
//  - Internal regs amt_ip[7:0] (credit) and price[7:0] (latched price) use exactly these names
//    (bench probes them hierarchically).
//  - Coin decode: one-hot values 1/2/5/10/20; zero or non-one-hot -> 0 (ignored, no error).
//  - Price table: A5=20, F2=30, E4=12, 10=5, 25=15. Any other code is invalid. All prices <= 31,
//    so chng never overflows 5 bits.
//  - FSM states: IDLE, COLLECT, DONE.
//    IDLE: disp=0 -> hold. disp=1 & valid item -> price<=table(item), amt_ip<=coin,
//      chng<=0, no_fund<=0, no_item<=0. If coin >= price: chng<=coin-price, go DONE.
//      Otherwise go COLLECT.
//      disp=1 & invalid item -> no_item<=1, price<=0, stay IDLE.
//    COLLECT: disp=1 -> sum=amt_ip+coin. If sum >= price: chng<=sum-price, amt_ip<=0, go DONE
//      (vend). Else amt_ip<=sum.
//      disp=0 -> coin this cycle ignored; chng<=amt_ip (refund), no_fund<=1, amt_ip<=0, go IDLE.
//    DONE: coins ignored; stay until disp=0, then go IDLE. chng holds value.
//  - One coin is credited per clock while coin_val is nonzero; a held coin is counted every cycle.
//  - Item changes mid-session are ignored; price is latched at session start.
//  - Arithmetic: 8-bit unsigned sum, max 30+20=50, no wrap. Compare uses >=. Exact payment
//    gives chng=0.
//  - rst mid-session: credit discarded, no refund, all outputs 0.
// STRUCTURE
//  - Shared package vending_pkg: state enum (IDLE/COLLECT/DONE), coin one-hot encodings,
//    item codes and prices.
//  - No sub-modules; coin decoder and price lookup are combinational functions.
// TESTING
//  1. Item A5, coins 1,1,20 on consecutive cycles -> amt_ip 1,2, then vend; chng=2,
//     no_fund=0, no_item=0; further 10-coins ignored in DONE.
//  2. Item F2, coins 20,20 -> vend on 2nd coin with chng=10. Following 5-coins are ignored
//     until disp=0.
//  3. Item E4, coin 1 held 3 cycles, disp->0 -> amt_ip=3 < 12; no_fund=1, chng=3, amt_ip=0.
//  4. Item 43 with disp=1 -> no_item=1, price=0, amt_ip stays 0, state IDLE.
//  5. Item 10 (price 5), coin 5 at session start -> exact pay, chng=0, DONE.
//     Coin_val=00011 mid-COLLECT -> ignored.
//  6. rst=1 during COLLECT with amt_ip=22 -> next edge all outputs 0, amt_ip=0, IDLE.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: FSM states, coin encodings,
// item codes, the fixed price table and the combinational decode/lookup helpers.
package vending_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] price;
  } price_t;

  localparam logic [4:0] COIN_1  = 5'b00001;
  localparam logic [4:0] COIN_2  = 5'b00010;
  localparam logic [4:0] COIN_5  = 5'b00100;
  localparam logic [4:0] COIN_10 = 5'b01000;
  localparam logic [4:0] COIN_20 = 5'b10000;

  localparam logic [7:0] ITEM_A5 = 8'hA5;
  localparam logic [7:0] ITEM_F2 = 8'hF2;
  localparam logic [7:0] ITEM_E4 = 8'hE4;
  localparam logic [7:0] ITEM_10 = 8'h10;
  localparam logic [7:0] ITEM_25 = 8'h25;

  localparam logic [7:0] PRICE_A5 = 8'd20;
  localparam logic [7:0] PRICE_F2 = 8'd30;
  localparam logic [7:0] PRICE_E4 = 8'd12;
  localparam logic [7:0] PRICE_10 = 8'd5;
  localparam logic [7:0] PRICE_25 = 8'd15;

  // Anything that is not exactly one-hot is worth nothing.
  function automatic logic [7:0] coin_value(input logic [4:0] c);
    case (c)
      COIN_1:  return 8'd1;
      COIN_2:  return 8'd2;
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      COIN_20: return 8'd20;
      default: return 8'd0;
    endcase
  endfunction

  function automatic price_t price_lookup(input logic [7:0] code);
    case (code)
      ITEM_A5: return '{valid: 1'b1, price: PRICE_A5};
      ITEM_F2: return '{valid: 1'b1, price: PRICE_F2};
      ITEM_E4: return '{valid: 1'b1, price: PRICE_E4};
      ITEM_10: return '{valid: 1'b1, price: PRICE_10};
      ITEM_25: return '{valid: 1'b1, price: PRICE_25};
      default: return '{valid: 1'b0, price: 8'd0};
    endcase
  endfunction

endpackage

// File: rtl/vending_machine.sv
// Single-item vending controller: latches price at session start, accumulates coins, vends with change.
// All outputs registered (one-cycle latency); no backpressure, one coin is credited per clock.
module vending_machine
  import vending_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] item,
  input  logic [4:0] coin_val,
  input  logic       disp,
  output logic [4:0] chng,
  output logic       no_fund,
  output logic       no_item
);

  state_e     state_q, state_d;
  logic [7:0] amt_ip, amt_ip_d;
  logic [7:0] price, price_d;
  logic [4:0] chng_q, chng_d;
  logic       no_fund_q, no_fund_d;
  logic       no_item_q, no_item_d;

  logic [7:0] coin;
  logic [7:0] sum;
  price_t     lookup;

  assign coin   = coin_value(coin_val);
  assign lookup = price_lookup(item);
  assign sum    = amt_ip + coin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      amt_ip    <= 8'd0;
      price     <= 8'd0;
      chng_q    <= 5'd0;
      no_fund_q <= 1'b0;
      no_item_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      amt_ip    <= amt_ip_d;
      price     <= price_d;
      chng_q    <= chng_d;
      no_fund_q <= no_fund_d;
      no_item_q <= no_item_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    amt_ip_d  = amt_ip;
    price_d   = price;
    chng_d    = chng_q;
    no_fund_d = no_fund_q;
    no_item_d = no_item_q;

    case (state_q)
      IDLE: begin
        if (disp) begin
          if (lookup.valid) begin
            price_d   = lookup.price;
            amt_ip_d  = coin;
            chng_d    = 5'd0;
            no_fund_d = 1'b0;
            no_item_d = 1'b0;
            if (coin >= lookup.price) begin
              chng_d  = 5'(coin - lookup.price);
              state_d = DONE;
            end else begin
              state_d = COLLECT;
            end
          end else begin
            no_item_d = 1'b1;
            price_d   = 8'd0;
          end
        end
      end
      COLLECT: begin
        if (disp) begin
          if (sum >= price) begin
            chng_d   = 5'(sum - price);
            amt_ip_d = 8'd0;
            state_d  = DONE;
          end else begin
            amt_ip_d = sum;
          end
        end else begin
          // Abandoned underfunded: refund the whole credit, so it always fits in 5 bits.
          chng_d    = amt_ip[4:0];
          no_fund_d = 1'b1;
          amt_ip_d  = 8'd0;
          state_d   = IDLE;
        end
      end
      DONE: begin
        if (!disp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign chng    = chng_q;
  assign no_fund = no_fund_q;
  assign no_item = no_item_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed scenarios plus a randomized session run against a purchase-level reference model.
module tb_vending_machine;
  import vending_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] item = 8'h00;
  logic [4:0] coin_val = 5'd0;
  logic       disp = 1'b0;
  logic [4:0] chng;
  logic       no_fund;
  logic       no_item;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a purchase is either "paying" or "served" (waiting for disp to drop).
  bit paying, served;
  int m_credit, m_price, m_chng;
  bit m_nf, m_ni;

  vending_machine dut (
    .clk(clk), .rst(rst), .item(item), .coin_val(coin_val), .disp(disp),
    .chng(chng), .no_fund(no_fund), .no_item(no_item)
  );

  always #5 clk = ~clk;

  function automatic int coin_worth(input logic [4:0] c);
    int vals[5] = '{1, 2, 5, 10, 20};
    if ($countones(c) != 1) return 0;
    for (int i = 0; i < 5; i++) if (c[i]) return vals[i];
    return 0;
  endfunction

  function automatic int price_of(input logic [7:0] code);
    case (code)
      8'hA5: return 20;
      8'hF2: return 30;
      8'hE4: return 12;
      8'h10: return 5;
      8'h25: return 15;
      default: return -1;
    endcase
  endfunction

  task automatic model_update(input logic [7:0] it, input logic [4:0] c, input logic d, input logic r);
    int v, p;
    v = coin_worth(c);
    p = price_of(it);
    if (r) begin
      paying = 0; served = 0; m_credit = 0; m_price = 0; m_chng = 0; m_nf = 0; m_ni = 0;
    end else if (served) begin
      if (!d) served = 0;
    end else if (paying) begin
      if (d) begin
        if (m_credit + v >= m_price) begin
          m_chng = m_credit + v - m_price; m_credit = 0; paying = 0; served = 1;
        end else m_credit += v;
      end else begin
        m_chng = m_credit; m_nf = 1; m_credit = 0; paying = 0;
      end
    end else if (d) begin
      if (p >= 0) begin
        m_price = p; m_credit = v; m_chng = 0; m_nf = 0; m_ni = 0;
        if (v >= p) begin m_chng = v - p; served = 1; end
        else paying = 1;
      end else begin
        m_ni = 1; m_price = 0;
      end
    end
  endtask

  task automatic step(input logic [7:0] it, input logic [4:0] c, input logic d, input logic r);
    @(negedge clk);
    item = it; coin_val = c; disp = d; rst = r;
    @(posedge clk);
    model_update(it, c, d, r);
    #1;
  endtask

  task automatic test_reset;
    step(8'h00, 5'd0, 1'b0, 1'b1);
    n_cmp += 6;
    if (chng !== 5'd0) begin n_err++; $display("FAIL reset_chng got %0d want 0", chng); end
    if (no_fund !== 1'b0) begin n_err++; $display("FAIL reset_no_fund got %b want 0", no_fund); end
    if (no_item !== 1'b0) begin n_err++; $display("FAIL reset_no_item got %b want 0", no_item); end
    if (dut.amt_ip !== 8'd0) begin n_err++; $display("FAIL reset_amt got %0d want 0", dut.amt_ip); end
    if (dut.price !== 8'd0) begin n_err++; $display("FAIL reset_price got %0d want 0", dut.price); end
    if (dut.state_q !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_vend_with_change;
    step(8'hA5, COIN_1, 1'b1, 1'b0);
    n_cmp++; if (dut.amt_ip !== 8'd1) begin n_err++; $display("FAIL a5_amt1 got %0d want 1", dut.amt_ip); end
    step(8'hA5, COIN_1, 1'b1, 1'b0);
    n_cmp++; if (dut.amt_ip !== 8'd2) begin n_err++; $display("FAIL a5_amt2 got %0d want 2", dut.amt_ip); end
    step(8'hA5, COIN_20, 1'b1, 1'b0);
    n_cmp += 4;
    if (chng !== 5'd2) begin n_err++; $display("FAIL a5_chng got %0d want 2", chng); end
    if (no_fund !== 1'b0) begin n_err++; $display("FAIL a5_no_fund got %b want 0", no_fund); end
    if (no_item !== 1'b0) begin n_err++; $display("FAIL a5_no_item got %b want 0", no_item); end
    if (dut.state_q !== DONE) begin n_err++; $display("FAIL a5_state got %0d want DONE", dut.state_q); end
    step(8'hA5, COIN_10, 1'b1, 1'b0);
    step(8'hA5, COIN_10, 1'b1, 1'b0);
    n_cmp++; if (chng !== 5'd2) begin n_err++; $display("FAIL a5_done_hold got %0d want 2", chng); end
    step(8'hA5, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL a5_end_state got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_two_coins;
    step(8'hF2, COIN_20, 1'b1, 1'b0);
    n_cmp++; if (dut.state_q !== COLLECT) begin n_err++; $display("FAIL f2_collect got %0d want COLLECT", dut.state_q); end
    step(8'hF2, COIN_20, 1'b1, 1'b0);
    n_cmp++; if (chng !== 5'd10) begin n_err++; $display("FAIL f2_chng got %0d want 10", chng); end
    step(8'hF2, COIN_5, 1'b1, 1'b0);
    step(8'hF2, COIN_5, 1'b1, 1'b0);
    n_cmp += 2;
    if (chng !== 5'd10) begin n_err++; $display("FAIL f2_hold got %0d want 10", chng); end
    if (dut.state_q !== DONE) begin n_err++; $display("FAIL f2_state got %0d want DONE", dut.state_q); end
    step(8'hF2, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_underfunded;
    for (int i = 0; i < 3; i++) step(8'hE4, COIN_1, 1'b1, 1'b0);
    n_cmp++; if (dut.amt_ip !== 8'd3) begin n_err++; $display("FAIL e4_amt got %0d want 3", dut.amt_ip); end
    step(8'hE4, COIN_1, 1'b0, 1'b0);
    n_cmp += 4;
    if (no_fund !== 1'b1) begin n_err++; $display("FAIL e4_no_fund got %b want 1", no_fund); end
    if (chng !== 5'd3) begin n_err++; $display("FAIL e4_refund got %0d want 3", chng); end
    if (dut.amt_ip !== 8'd0) begin n_err++; $display("FAIL e4_amt_clr got %0d want 0", dut.amt_ip); end
    if (dut.state_q !== IDLE) begin n_err++; $display("FAIL e4_state got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_bad_item;
    step(8'h00, 5'd0, 1'b0, 1'b1);
    step(8'h43, 5'd0, 1'b1, 1'b0);
    n_cmp += 4;
    if (no_item !== 1'b1) begin n_err++; $display("FAIL bad_no_item got %b want 1", no_item); end
    if (dut.price !== 8'd0) begin n_err++; $display("FAIL bad_price got %0d want 0", dut.price); end
    if (dut.amt_ip !== 8'd0) begin n_err++; $display("FAIL bad_amt got %0d want 0", dut.amt_ip); end
    if (dut.state_q !== IDLE) begin n_err++; $display("FAIL bad_state got %0d want IDLE", dut.state_q); end
    step(8'h43, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_exact_and_invalid_coin;
    step(8'h10, COIN_5, 1'b1, 1'b0);
    n_cmp += 3;
    if (chng !== 5'd0) begin n_err++; $display("FAIL exact_chng got %0d want 0", chng); end
    if (no_item !== 1'b0) begin n_err++; $display("FAIL exact_no_item got %b want 0", no_item); end
    if (dut.state_q !== DONE) begin n_err++; $display("FAIL exact_state got %0d want DONE", dut.state_q); end
    step(8'h10, 5'd0, 1'b0, 1'b0);
    step(8'h10, 5'd0, 1'b1, 1'b0);
    step(8'h10, 5'b00011, 1'b1, 1'b0);
    n_cmp += 2;
    if (dut.amt_ip !== 8'd0) begin n_err++; $display("FAIL multihot_amt got %0d want 0", dut.amt_ip); end
    if (dut.state_q !== COLLECT) begin n_err++; $display("FAIL multihot_state got %0d want COLLECT", dut.state_q); end
    step(8'h10, COIN_5, 1'b1, 1'b0);
    n_cmp++; if (chng !== 5'd0) begin n_err++; $display("FAIL exact2_chng got %0d want 0", chng); end
    step(8'h10, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_session;
    step(8'hF2, COIN_20, 1'b1, 1'b0);
    step(8'hF2, COIN_2, 1'b1, 1'b0);
    n_cmp++; if (dut.amt_ip !== 8'd22) begin n_err++; $display("FAIL rst_pre_amt got %0d want 22", dut.amt_ip); end
    step(8'hF2, COIN_5, 1'b1, 1'b1);
    n_cmp += 5;
    if (chng !== 5'd0) begin n_err++; $display("FAIL rst_chng got %0d want 0", chng); end
    if (no_fund !== 1'b0) begin n_err++; $display("FAIL rst_no_fund got %b want 0", no_fund); end
    if (no_item !== 1'b0) begin n_err++; $display("FAIL rst_no_item got %b want 0", no_item); end
    if (dut.amt_ip !== 8'd0) begin n_err++; $display("FAIL rst_amt got %0d want 0", dut.amt_ip); end
    if (dut.state_q !== IDLE) begin n_err++; $display("FAIL rst_state got %0d want IDLE", dut.state_q); end
    step(8'h00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] codes[6] = '{8'hA5, 8'hF2, 8'hE4, 8'h10, 8'h25, 8'h00};
    logic [4:0] onehot[5] = '{COIN_1, COIN_2, COIN_5, COIN_10, COIN_20};
    logic [7:0] it, drv_it;
    logic [4:0] c;
    logic       r;
    for (int s = 0; s < 60; s++) begin
      it = codes[$urandom_range(0, 5)];
      if (it == 8'h00) it = 8'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 10)); k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: c = onehot[$urandom_range(0, 4)];
          6, 7:             c = 5'd0;
          default:          c = 5'($urandom);
        endcase
        drv_it = ($urandom_range(0, 4) == 0) ? 8'($urandom) : it;
        if (k == 0) drv_it = it;
        r = ($urandom_range(0, 79) == 0);
        step(drv_it, c, 1'b1, r);
        n_cmp += 5;
        if (chng !== 5'(m_chng)) begin n_err++; $display("FAIL rnd_chng s%0d got %0d want %0d", s, chng, m_chng); end
        if (no_fund !== m_nf) begin n_err++; $display("FAIL rnd_no_fund s%0d got %b want %b", s, no_fund, m_nf); end
        if (no_item !== m_ni) begin n_err++; $display("FAIL rnd_no_item s%0d got %b want %b", s, no_item, m_ni); end
        if (dut.amt_ip !== 8'(m_credit)) begin n_err++; $display("FAIL rnd_amt s%0d got %0d want %0d", s, dut.amt_ip, m_credit); end
        if (dut.price !== 8'(m_price)) begin n_err++; $display("FAIL rnd_price s%0d got %0d want %0d", s, dut.price, m_price); end
      end
      step(it, onehot[$urandom_range(0, 4)], 1'b0, 1'b0);
      n_cmp += 3;
      if (chng !== 5'(m_chng)) begin n_err++; $display("FAIL rnd_end_chng s%0d got %0d want %0d", s, chng, m_chng); end
      if (no_fund !== m_nf) begin n_err++; $display("FAIL rnd_end_no_fund s%0d got %b want %b", s, no_fund, m_nf); end
      if (dut.amt_ip !== 8'(m_credit)) begin n_err++; $display("FAIL rnd_end_amt s%0d got %0d want %0d", s, dut.amt_ip, m_credit); end
      if ($urandom_range(0, 1) == 1) step(it, 5'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_vend_with_change;
    test_two_coins;
    test_underfunded;
    test_bad_item;
    test_exact_and_invalid_coin;
    test_reset_mid_session;
    test_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
